// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// States, entry layout, NOP encoding and the alignment check.
package fetch_unit_pkg;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP,
      S_FAULT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic is_misaligned(input logic [31:0] a);
      return a[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: imem request/ack, redirect input,
// instruction valid/ready output and the sticky fault flag.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fault;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect_valid, redirect_target,
      output inst_valid, inst, inst_pc,
      input  inst_ready,
      output fault
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect_valid, redirect_target,
      input  inst_valid, inst, inst_pc,
      output inst_ready,
      input  fault
   );

endinterface

// File: rtl/fetch_unit_queue.sv
// Instruction queue of {pc, inst} pairs with a registered head.
// The head keeps its last value while the queue is empty.
module fetch_unit_queue
   import fetch_unit_pkg::*;
#(
   parameter int           QDEPTH     = 2,
   parameter fetch_entry_t RESET_HEAD = '0,
   localparam int          AW         = $clog2(QDEPTH),
   localparam int          CW         = AW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  fetch_entry_t  data_i,
   output fetch_entry_t  head_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [QDEPTH];
   fetch_entry_t  head_q, head_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   // next pointers, count and head; flush wins over push/pop
   always_comb begin
      do_push = push_i & ~flush_i;
      do_pop  = pop_i & (cnt_q != '0) & ~flush_i;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         if (cnt_d != '0) begin
            if (do_push && (wr_q == rd_d)) head_d = data_i;
            else                           head_d = mem_q[rd_d];
         end
      end
   end

   // storage array, written only on accepted pushes
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   // pointer, count and head registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= RESET_HEAD;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   assign head_o  = head_q;
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM,
// redirect flush and misaligned-target fault handling.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          QDEPTH   = 2
) (
   input logic          clock,
   input logic          reset,
   fetch_unit_if.master bus
);

   localparam int            CW      = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          fault_q, fault_d;
   logic          q_push, q_pop, q_flush, q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_head;
   fetch_entry_t  q_data;
   logic          head_valid;

   assign head_valid = ~q_empty & (state_q != S_FAULT);

   // next state, pc and queue controls; redirect has priority
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      fault_d = fault_q;
      q_push  = 1'b0;
      q_flush = 1'b0;
      q_pop   = head_valid & bus.inst_ready;
      q_data  = '{pc: addr_q, inst: bus.imem_rdata};
      if (bus.redirect_valid && (state_q != S_FAULT)) begin
         q_flush = 1'b1;
         if (is_misaligned(bus.redirect_target)) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
         end else begin
            pc_d = bus.redirect_target;
            unique case (state_q)
               S_WAIT, S_DROP:
                  state_d = bus.imem_ack ? S_IDLE : S_DROP;
               default:
                  state_d = S_IDLE;
            endcase
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (q_count < DEPTH_C) begin
                  addr_d  = pc_q;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.imem_ack) begin
                  q_push  = 1'b1;
                  pc_d    = addr_q + 32'd4;
                  state_d = S_IDLE;
               end
            end
            S_DROP: begin
               if (bus.imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_FAULT;
         endcase
      end
   end

   // fetch control registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         fault_q <= fault_d;
      end
   end

   fetch_unit_queue #(
      .QDEPTH     (QDEPTH),
      .RESET_HEAD ({RESET_PC, NOP_INST})
   ) u_queue (
      .clock   (clock),
      .reset   (reset),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .flush_i (q_flush),
      .data_i  (q_data),
      .head_o  (q_head),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   assign bus.imem_req   = (state_q == S_WAIT) || (state_q == S_DROP);
   assign bus.imem_addr  = addr_q;
   assign bus.inst_valid = head_valid;
   assign bus.inst       = q_head.inst;
   assign bus.inst_pc    = q_head.pc;
   assign bus.fault      = fault_q;

endmodule
